// File: rtl/reg_scoreboard_pkg.sv
// Shared parameters and FSM encoding for the register scoreboard.
package reg_scoreboard_pkg;

  localparam int W_RD_DEF  = 4;
  localparam int W_CNT_DEF = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ACK   = 2'd2
  } sb_state_e;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Saturating up/down counter of outstanding writes for one register.
module sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o,
  output logic         max_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
  assign max_o  = (cnt_q == '1);

  // NOTE: cnt_d gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !max_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !zero_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register outstanding-write counters, decode hazard
// detection with same-cycle release bypass, and a drain/ack quiesce handshake.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int W_RD  = W_RD_DEF,
  parameter int W_CNT = W_CNT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 src_v_i,
  input  logic [W_RD-1:0]      src0_r_i,
  input  logic [W_RD-1:0]      src1_r_i,
  input  logic                 src0_use_i,
  input  logic                 src1_use_i,
  input  logic                 rsv_v_i,
  input  logic [W_RD-1:0]      rsv_r_i,
  input  logic                 rel_v_i,
  input  logic [W_RD-1:0]      rel_r_i,
  input  logic                 drain_req_i,
  output logic                 reserved_o,
  output logic [2**W_RD-1:0]   busy_o,
  output logic                 drain_ack_o,
  output logic                 err_o
);

  localparam int N_REG = 2**W_RD;

  sb_state_e        state_q;
  logic             drain_ack_q;
  logic             err_q;

  logic [W_CNT-1:0] cnt [N_REG];
  logic [N_REG-1:0] zero, full, one, inc, dec, eff_busy;
  logic             run, src0_haz, src1_haz, dest_full, rsv_acc;

  for (genvar g = 0; g < N_REG; g++) begin : g_cnt
    sb_counter #(.W(W_CNT)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc_i  (inc[g]),
      .dec_i  (dec[g]),
      .cnt_o  (cnt[g]),
      .zero_o (zero[g]),
      .max_o  (full[g])
    );
    assign one[g] = (cnt[g] == W_CNT'(1));
  end

  always_comb begin
    dec = '0;
    inc = '0;
    if (rel_v_i) dec[rel_r_i] = 1'b1;
    if (rsv_acc) inc[rsv_r_i] = 1'b1;
  end

  // A register whose last outstanding write retires this cycle is already free.
  assign eff_busy  = ~zero & ~(dec & one);
  assign src0_haz  = src0_use_i && eff_busy[src0_r_i];
  assign src1_haz  = src1_use_i && eff_busy[src1_r_i];
  assign dest_full = rsv_v_i && full[rsv_r_i] && !dec[rsv_r_i];
  assign run       = (state_q == ST_RUN);

  assign reserved_o = src_v_i && (src0_haz || src1_haz || dest_full || !run);
  assign rsv_acc    = rsv_v_i && run && !dest_full && !(src_v_i && (src0_haz || src1_haz));

  assign busy_o      = ~zero;
  assign drain_ack_o = drain_ack_q;
  assign err_o       = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_ack_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (rel_v_i && zero[rel_r_i]) err_q <= 1'b1;
      case (state_q)
        ST_RUN: begin
          if (drain_req_i) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (&zero) begin
            state_q     <= ST_ACK;
            drain_ack_q <= 1'b1;
          end
        end
        ST_ACK: begin
          if (!drain_req_i) begin
            state_q     <= ST_RUN;
            drain_ack_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          drain_ack_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard-driven bench for reg_scoreboard: expected busy vectors are queued
// at drive time and compared after the clock edge.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        src_v_i, src0_use_i, src1_use_i, rsv_v_i, rel_v_i, drain_req_i;
  logic [3:0]  src0_r_i, src1_r_i, rsv_r_i, rel_r_i;
  logic        reserved_o, drain_ack_o, err_o;
  logic [15:0] busy_o;

  int          checks = 0;
  int          errors = 0;
  int          mcnt [16];
  logic [15:0] exp_q [$];

  reg_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .src_v_i     (src_v_i),
    .src0_r_i    (src0_r_i),
    .src1_r_i    (src1_r_i),
    .src0_use_i  (src0_use_i),
    .src1_use_i  (src1_use_i),
    .rsv_v_i     (rsv_v_i),
    .rsv_r_i     (rsv_r_i),
    .rel_v_i     (rel_v_i),
    .rel_r_i     (rel_r_i),
    .drain_req_i (drain_req_i),
    .reserved_o  (reserved_o),
    .busy_o      (busy_o),
    .drain_ack_o (drain_ack_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic idle();
    src_v_i = 0; src0_use_i = 0; src1_use_i = 0; rsv_v_i = 0; rel_v_i = 0;
    src0_r_i = 0; src1_r_i = 0; rsv_r_i = 0; rel_r_i = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mcnt[i] = 0;
    exp_q.delete();
  endtask

  // Advance one edge; acc says whether the bench expects the reservation taken.
  task automatic step(input bit acc, input string tag);
    logic [15:0] e;
    if (acc) mcnt[rsv_r_i]++;
    if (rel_v_i && mcnt[rel_r_i] != 0) mcnt[rel_r_i]--;
    for (int i = 0; i < 16; i++) e[i] = (mcnt[i] != 0);
    exp_q.push_back(e);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if (busy_o !== e) begin
      errors++;
      $display("FAIL busy_%s got %h expected %h", tag, busy_o, e);
    end
  endtask

  task automatic test_reset();
    reset = 1; drain_req_i = 0; idle(); model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    src_v_i = 1;
    #1;
    checks++;
    if (busy_o !== 16'h0 || err_o !== 1'b0 || drain_ack_o !== 1'b0 || reserved_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got busy=%h err=%b ack=%b rsv=%b expected 0 0 0 0",
               busy_o, err_o, drain_ack_o, reserved_o);
    end
    idle();
  endtask

  task automatic test_basic();
    src_v_i = 1; rsv_v_i = 1; rsv_r_i = 3;
    #1 checks++;
    if (reserved_o !== 1'b0) begin errors++; $display("FAIL basic_rsv got %b expected 0", reserved_o); end
    step(1, "basic_r3");
    idle(); src_v_i = 1; src0_use_i = 1; src0_r_i = 3;
    #1 checks++;
    if (reserved_o !== 1'b1) begin errors++; $display("FAIL basic_hazard got %b expected 1", reserved_o); end
    step(0, "basic_hold");
    rel_v_i = 1; rel_r_i = 3;
    #1 checks++;
    if (reserved_o !== 1'b0) begin errors++; $display("FAIL basic_bypass got %b expected 0", reserved_o); end
    step(0, "basic_rel");
    idle();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) begin
      src_v_i = 1; rsv_v_i = 1; rsv_r_i = 5;
      #1 checks++;
      if (reserved_o !== 1'b0) begin errors++; $display("FAIL sat_fill%0d got %b expected 0", k, reserved_o); end
      step(1, "sat_fill");
    end
    #1 checks++;
    if (reserved_o !== 1'b1) begin errors++; $display("FAIL sat_full got %b expected 1", reserved_o); end
    step(0, "sat_full");
    rel_v_i = 1; rel_r_i = 5;
    #1 checks++;
    if (reserved_o !== 1'b0) begin errors++; $display("FAIL sat_relbypass got %b expected 0", reserved_o); end
    step(1, "sat_swap");
    idle();
    for (int k = 0; k < 3; k++) begin
      rel_v_i = 1; rel_r_i = 5;
      step(0, "sat_drain");
    end
    idle();
  endtask

  task automatic test_same_cycle();
    rsv_v_i = 1; rsv_r_i = 2;
    step(1, "same_first");
    src_v_i = 1; src0_use_i = 1; src0_r_i = 2; rel_v_i = 1; rel_r_i = 2;
    #1 checks++;
    if (reserved_o !== 1'b0) begin errors++; $display("FAIL same_selfsrc got %b expected 0", reserved_o); end
    step(1, "same_swap");
    idle(); rel_v_i = 1; rel_r_i = 2;
    step(0, "same_release");
    idle();
  endtask

  task automatic test_err();
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear got %b expected 0", err_o); end
    rel_v_i = 1; rel_r_i = 7;
    step(0, "err_rel");
    idle();
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b expected 1", err_o); end
    step(0, "err_idle1");
    step(0, "err_idle2");
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b expected 1", err_o); end
  endtask

  task automatic test_drain();
    rsv_v_i = 1; rsv_r_i = 1;
    step(1, "drn_r1a");
    step(1, "drn_r1b");
    idle(); drain_req_i = 1;
    step(0, "drn_enter");
    src_v_i = 1; rsv_v_i = 1; rsv_r_i = 9;
    #1 checks++;
    if (reserved_o !== 1'b1) begin errors++; $display("FAIL drn_block got %b expected 1", reserved_o); end
    step(0, "drn_blocked");
    idle(); rel_v_i = 1; rel_r_i = 1;
    step(0, "drn_rel1");
    checks++;
    if (drain_ack_o !== 1'b0) begin errors++; $display("FAIL drn_early_ack got %b expected 0", drain_ack_o); end
    step(0, "drn_rel2");
    idle();
    for (int i = 0; i < 5 && drain_ack_o !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (drain_ack_o !== 1'b1) begin errors++; $display("FAIL drn_ack got %b expected 1", drain_ack_o); end
    src_v_i = 1;
    #1 checks++;
    if (reserved_o !== 1'b1) begin errors++; $display("FAIL drn_ack_block got %b expected 1", reserved_o); end
    step(0, "drn_hold");
    checks++;
    if (drain_ack_o !== 1'b1) begin errors++; $display("FAIL drn_ack_hold got %b expected 1", drain_ack_o); end
    idle(); drain_req_i = 0;
    step(0, "drn_exit");
    checks++;
    if (drain_ack_o !== 1'b0) begin errors++; $display("FAIL drn_ack_drop got %b expected 0", drain_ack_o); end
    src_v_i = 1; rsv_v_i = 1; rsv_r_i = 9;
    #1 checks++;
    if (reserved_o !== 1'b0) begin errors++; $display("FAIL drn_resume got %b expected 0", reserved_o); end
    step(1, "drn_resume");
    idle();
  endtask

  task automatic test_reset_mid();
    rsv_v_i = 1; rsv_r_i = 4;
    step(1, "rst_r4");
    idle(); drain_req_i = 1;
    step(0, "rst_drain");
    @(negedge clk);
    reset = 1;
    src_v_i = 1;
    #1 checks++;
    if (busy_o !== 16'h0 || drain_ack_o !== 1'b0 || err_o !== 1'b0 || reserved_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got busy=%h ack=%b err=%b rsv=%b expected 0 0 0 0",
               busy_o, drain_ack_o, err_o, reserved_o);
    end
    drain_req_i = 0; idle(); model_clear();
    @(posedge clk); #1 reset = 0;
    src_v_i = 1; rsv_v_i = 1; rsv_r_i = 4;
    #1 checks++;
    if (reserved_o !== 1'b0) begin errors++; $display("FAIL rst_run got %b expected 0", reserved_o); end
    step(1, "rst_after");
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_same_cycle();
    test_err();
    test_drain();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter W_RD, default 4, SHALL set register-index width; register count N_REG = 2**W_RD.
REQ-002 Parameter W_CNT, default 2, SHALL set per-register outstanding-write counter width; CNT_MAX = 2**W_CNT-1.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  clock, all state updates on rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 src_v_i  in  1  decode stage holds a valid instruction.
REQ-007 src0_r_i, src1_r_i  in  W_RD  source register indices.
REQ-008 src0_use_i, src1_use_i  in  1  the corresponding source is actually read.
REQ-009 rsv_v_i  in  1  decode requests a destination reservation this cycle.
REQ-010 rsv_r_i  in  W_RD  destination register to reserve.
REQ-011 rel_v_i  in  1  writeback retires an instruction that held a reservation; squashed instructions also pulse this.
REQ-012 rel_r_i  in  W_RD  register being released.
REQ-013 drain_req_i  in  1  request to quiesce (serialising instruction); level, held until drain_ack_o.
REQ-014 reserved_o  out  1  hazard: decode must stall.
REQ-015 busy_o  out  N_REG  per-register "counter non-zero" vector, registered.
REQ-016 drain_ack_o  out  1  all counters zero while draining.
REQ-017 err_o  out  1  sticky: release of a register whose counter is zero.

Function
REQ-018 Each register SHALL own a W_CNT-bit counter of outstanding writes.
REQ-019 Effective busy for hazard: cnt[r]!=0 and not (rel_v_i and rel_r_i==r and cnt[r]==1) -- same-cycle release bypass.
REQ-020 reserved_o SHALL be combinational: src_v_i and (src0 hazard or src1 hazard or dest-full or state!=RUN).
REQ-021 srcN hazard = srcN_use_i and effective busy(srcN_r_i).
REQ-022 dest-full = rsv_v_i and cnt[rsv_r_i]==CNT_MAX and not a same-cycle release of rsv_r_i.
REQ-023 A reservation SHALL be accepted only when rsv_v_i and not reserved_o; the counter increments next edge.
REQ-024 A release SHALL decrement its counter next edge; at zero it SHALL not wrap, and err_o SHALL set.
REQ-025 Accepted reservation and release on the same register same cycle SHALL leave the counter unchanged.
REQ-026 A source equal to the destination of the same instruction SHALL check only the pre-update counter (no self-hazard).
REQ-027 FSM states RUN, DRAIN, ACK; reset to RUN.
REQ-028 RUN->DRAIN when drain_req_i=1; reservations SHALL be blocked in DRAIN and ACK.
REQ-029 DRAIN->ACK when all counters zero (registered view); drain_ack_o=1 only in ACK.
REQ-030 ACK->RUN when drain_req_i=0; ACK holds while drain_req_i=1.
REQ-031 Releases SHALL be processed in every state.
REQ-032 Latency: hazard clears in the same cycle as the final release (bypass); busy_o updates one cycle later.

Reset
REQ-033 On reset: all counters 0, busy_o=0, state RUN, drain_ack_o=0, err_o=0; reserved_o then reflects only inputs.
REQ-034 Reset asserted mid-operation SHALL discard all reservations immediately; the pipeline is reset together with this block.

Structure
REQ-035 W_RD, W_CNT default and FSM state encodings SHALL live in the shared params include.
REQ-036 One sub-module, sb_counter (single saturating up/down counter with zero/max flags), SHALL be instantiated N_REG times.

Verification
REQ-037 Reserve r3 (rsv_v_i=1, src uses 0) -> next cycle busy_o[3]=1; src0_r_i=3 use=1 -> reserved_o=1; rel r3 -> reserved_o=0 same cycle, busy_o[3]=0 next.
REQ-038 Reserve r5 three times, fourth rsv_v_i on r5 -> reserved_o=1, cnt stays 3; fourth request with simultaneous rel r5 -> accepted, cnt stays 3.
REQ-039 Reserve r2 and release r2 same cycle with cnt[r2]=1 -> cnt stays 1, busy_o[2]=1.
REQ-040 rel r7 with cnt 0 -> err_o=1 and stays 1 until reset, cnt[r7]=0.
REQ-041 cnt r1=2, drain_req_i=1 -> reserved_o=1 for valid src, two releases -> drain_ack_o=1 next cycle; drop drain_req_i -> RUN, reservations accepted.
REQ-042 Assert reset with r4 busy and state DRAIN -> busy_o=0, state RUN, drain_ack_o=0 without clock edge.
